uart_tx_framer: RTL

UART_TX_FRAMER -- requirements
Module: uart_tx_framer

---
 rtl/uart_tx_framer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_framer.sv
// UART transmit framer: serialises one accepted byte into start/data/parity/stop
// bits, timed by an external oversampling baud tick.
module uart_tx_framer #(
   parameter int unsigned OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       bclk_tick,
   input  logic       tx_en,
   input  logic [1:0] wls,
   input  logic       stb,
   input  logic       pen,
   input  logic       eps,
   input  logic       stick_par,
   input  logic       break_ctl,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       txd,
   output logic       tx_busy,
   output logic       tx_done
);

   localparam int unsigned CNT_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] tick_cnt;
   logic [2:0]       bit_idx;
   logic [1:0]       wls_q;
   logic             stb_q;
   logic             pen_q;
   logic             par_q;
   logic             stop_cnt;
   logic [7:0]       shreg;
   logic             line_q;
   logic             txd_q;
   logic             done_q;
   logic             bit_end;
   logic [2:0]       last_idx;

   // Parity over the data bits that will actually be sent for word length w.
   function automatic logic calc_parity(input logic [7:0] d, input logic [1:0] w,
                                        input logic e, input logic s);
      logic [7:0] mask;
      logic       x;
      case (w)
         2'b00:   mask = 8'h1F;
         2'b01:   mask = 8'h3F;
         2'b10:   mask = 8'h7F;
         default: mask = 8'hFF;
      endcase
      x = ^(d & mask);
      if (s) return ~e;
      return e ? x : ~x;
   endfunction

   // Line value as it appears on txd, with break overriding to space.
   function automatic logic line_out(input logic v);
      return v & ~break_ctl;
   endfunction

   assign tx_ready = tx_en & (state == IDLE);
   assign tx_busy  = (state != IDLE);
   assign txd      = txd_q;
   assign tx_done  = done_q;
   assign bit_end  = bclk_tick & (tick_cnt == CNT_LAST);
   assign last_idx = 3'(wls_q) + 3'd4;

   // Frame sequencer; txd is re-registered every cycle so break has one-clk latency.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= IDLE;
         tick_cnt <= '0;
         bit_idx  <= '0;
         wls_q    <= '0;
         stb_q    <= 1'b0;
         pen_q    <= 1'b0;
         par_q    <= 1'b0;
         stop_cnt <= 1'b0;
         shreg    <= '0;
         line_q   <= 1'b1;
         txd_q    <= 1'b1;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         txd_q  <= line_out(line_q);
         if ((state != IDLE) && bclk_tick) begin
            tick_cnt <= bit_end ? '0 : tick_cnt + 1'b1;
         end
         case (state)
            IDLE: begin
               if (tx_en && tx_valid) begin
                  state    <= START;
                  tick_cnt <= '0;
                  shreg    <= tx_data;
                  wls_q    <= wls;
                  stb_q    <= stb;
                  pen_q    <= pen;
                  par_q    <= calc_parity(tx_data, wls, eps, stick_par);
                  line_q   <= 1'b0;
                  txd_q    <= line_out(1'b0);
               end
            end
            START: begin
               if (bit_end) begin
                  state   <= DATA;
                  bit_idx <= '0;
                  line_q  <= shreg[0];
                  txd_q   <= line_out(shreg[0]);
               end
            end
            DATA: begin
               if (bit_end) begin
                  if (bit_idx == last_idx) begin
                     state    <= pen_q ? PARITY : STOP;
                     stop_cnt <= 1'b0;
                     line_q   <= pen_q ? par_q : 1'b1;
                     txd_q    <= line_out(pen_q ? par_q : 1'b1);
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     shreg   <= shreg >> 1;
                     line_q  <= shreg[1];
                     txd_q   <= line_out(shreg[1]);
                  end
               end
            end
            PARITY: begin
               if (bit_end) begin
                  state    <= STOP;
                  stop_cnt <= 1'b0;
                  line_q   <= 1'b1;
                  txd_q    <= line_out(1'b1);
               end
            end
            STOP: begin
               if (bit_end) begin
                  if (stb_q && !stop_cnt) begin
                     stop_cnt <= 1'b1;
                  end else begin
                     state  <= IDLE;
                     done_q <= 1'b1;
                  end
               end
            end
            default: begin
               state  <= IDLE;
               line_q <= 1'b1;
            end
         endcase
      end
   end

endmodule
